// File: rtl/spell_mem_ctrl_if.sv
// Bus bundle for spell_mem_ctrl: CPU data port, I/O register block port and
// external memory port. The controller takes the slave modport and the CPU side
// together with the attached slaves takes the master modport.
interface spell_mem_ctrl_if;
  // CPU side
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_write;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       mem_err;
  // I/O register block
  logic       io_select;
  logic [7:0] io_addr;
  logic [7:0] io_data_in;
  logic       io_write;
  logic [7:0] io_data_out;
  logic       io_data_ready;
  // External memory
  logic       ext_req;
  logic [7:0] ext_addr;
  logic [7:0] ext_wdata;
  logic       ext_write;
  logic [7:0] ext_rdata;
  logic       ext_ack;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_write,
    input  mem_rdata, mem_ready, mem_err,
    input  io_select, io_addr, io_data_in, io_write,
    output io_data_out, io_data_ready,
    input  ext_req, ext_addr, ext_wdata, ext_write,
    output ext_rdata, ext_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_write,
    output mem_rdata, mem_ready, mem_err,
    output io_select, io_addr, io_data_in, io_write,
    input  io_data_out, io_data_ready,
    output ext_req, ext_addr, ext_wdata, ext_write,
    input  ext_rdata, ext_ack
  );
endinterface

// File: rtl/spell_mem_ctrl.sv
// Data-memory bus controller for the spell CPU. Decodes each load/store into
// the 32-byte scratch RAM, the I/O register block or the external memory port
// and answers the CPU with a one-cycle registered ready pulse.
// Optional wait timeout: define SPELL_MEM_CTRL_TIMEOUT_EN (adds TIMEOUT parameter).
module spell_mem_ctrl #(
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 255,
`endif
  parameter logic [7:0]  IO_BASE = 8'h20,
  parameter logic [7:0]  IO_TOP  = 8'h3F
) (
  input logic            clk,
  input logic            rst_n,
  spell_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIoWait, StExtWait, StResp} state_e;

  localparam logic [7:0] RamTop = 8'h1F;

  state_e     state_q, state_d;
  logic [7:0] mem_rdata_q, mem_rdata_d;
  logic       mem_ready_q, mem_ready_d;
  logic       io_select_q, io_select_d;
  logic [7:0] io_addr_q, io_addr_d;
  logic [7:0] io_data_in_q, io_data_in_d;
  logic       io_write_q, io_write_d;
  logic       ext_req_q, ext_req_d;
  logic [7:0] ext_addr_q, ext_addr_d;
  logic [7:0] ext_wdata_q, ext_wdata_d;
  logic       ext_write_q, ext_write_d;
  logic       write_q, write_d;

  logic [7:0] ram_q [32];
  logic       ram_we;
  logic       is_ram, is_io;

`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       expired;
  assign expired = (cnt_q == TimeoutLast);
`endif

  assign is_ram = (bus.mem_addr <= RamTop);
  assign is_io  = (bus.mem_addr >= IO_BASE) && (bus.mem_addr <= IO_TOP);

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    mem_rdata_d  = mem_rdata_q;
    mem_ready_d  = 1'b0;
    io_select_d  = io_select_q;
    io_addr_d    = io_addr_q;
    io_data_in_d = io_data_in_q;
    io_write_d   = io_write_q;
    ext_req_d    = ext_req_q;
    ext_addr_d   = ext_addr_q;
    ext_wdata_d  = ext_wdata_q;
    ext_write_d  = ext_write_q;
    write_d      = write_q;
    ram_we       = 1'b0;
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.mem_req) begin
          write_d = bus.mem_write;
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
          cnt_d   = 8'h00;
`endif
          if (is_ram) begin
            // Reset must not let a pending store slip into the RAM
            ram_we      = bus.mem_write & rst_n;
            mem_rdata_d = bus.mem_write ? 8'h00 : ram_q[bus.mem_addr[4:0]];
            mem_ready_d = 1'b1;
            state_d     = StResp;
          end else if (is_io) begin
            io_select_d  = 1'b1;
            io_addr_d    = bus.mem_addr;
            io_data_in_d = bus.mem_wdata;
            io_write_d   = bus.mem_write;
            state_d      = StIoWait;
          end else begin
            ext_req_d   = 1'b1;
            ext_addr_d  = bus.mem_addr;
            ext_wdata_d = bus.mem_wdata;
            ext_write_d = bus.mem_write;
            state_d     = StExtWait;
          end
        end
      end
      StIoWait: begin
        if (bus.io_data_ready) begin
          mem_rdata_d = write_q ? 8'h00 : bus.io_data_out;
          io_select_d = 1'b0;
          io_write_d  = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = StResp;
        end
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
        else if (expired) begin
          mem_rdata_d = 8'hFF;
          err_d       = 1'b1;
          io_select_d = 1'b0;
          io_write_d  = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StExtWait: begin
        if (bus.ext_ack) begin
          mem_rdata_d = write_q ? 8'h00 : bus.ext_rdata;
          ext_req_d   = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = StResp;
        end
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
        else if (expired) begin
          mem_rdata_d = 8'hFF;
          err_d       = 1'b1;
          ext_req_d   = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StResp: begin
        // One idle cycle follows, so io_select stays low for RESP + IDLE
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_rdata_q  <= 8'h00;
      mem_ready_q  <= 1'b0;
      io_select_q  <= 1'b0;
      io_addr_q    <= 8'h00;
      io_data_in_q <= 8'h00;
      io_write_q   <= 1'b0;
      ext_req_q    <= 1'b0;
      ext_addr_q   <= 8'h00;
      ext_wdata_q  <= 8'h00;
      ext_write_q  <= 1'b0;
      write_q      <= 1'b0;
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
      cnt_q        <= 8'h00;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_ready_q  <= mem_ready_d;
      io_select_q  <= io_select_d;
      io_addr_q    <= io_addr_d;
      io_data_in_q <= io_data_in_d;
      io_write_q   <= io_write_d;
      ext_req_q    <= ext_req_d;
      ext_addr_q   <= ext_addr_d;
      ext_wdata_q  <= ext_wdata_d;
      ext_write_q  <= ext_write_d;
      write_q      <= write_d;
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Scratch RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.io_select  = io_select_q;
  assign bus.io_addr    = io_addr_q;
  assign bus.io_data_in = io_data_in_q;
  assign bus.io_write   = io_write_q;
  assign bus.ext_req    = ext_req_q;
  assign bus.ext_addr   = ext_addr_q;
  assign bus.ext_wdata  = ext_wdata_q;
  assign bus.ext_write  = ext_write_q;
`ifdef SPELL_MEM_CTRL_TIMEOUT_EN
  assign bus.mem_err    = err_q;
`else
  assign bus.mem_err    = 1'b0;
`endif

endmodule

// File: doc/spell_mem_ctrl.md
Name: spell_mem_ctrl

Overview:
- Data-memory bus controller between the spell CPU core and its data-side slaves.
- Decodes each CPU load/store by address into one of three targets: internal 32-byte scratch RAM, the memory-mapped I/O register block (select/addr/data/write, answered by data_ready), or an external memory port with req/ack handshake.
- Returns a single-cycle ready pulse with read data to the CPU.
- Guarantees the I/O select strobe drops between transactions, so the I/O block's write edge detection (PINx toggle) fires exactly once per store.

Parameters:
- TIMEOUT, 255: wait-cycle limit (1..255) for I/O or external completion; used only with the optional feature.
- IO_BASE, 8'h20: first address of the I/O region.
- IO_TOP, 8'h3F: last address of the I/O region.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_req  in  1  CPU request strobe; sampled only in IDLE
- mem_addr  in  8  CPU address
- mem_wdata  in  8  CPU store data
- mem_write  in  1  1 = store, 0 = load
- mem_rdata  out  8  load data; valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  high with mem_ready when the transaction timed out
- io_select  out  1  I/O block select
- io_addr  out  8  I/O register address
- io_data_in  out  8  store data to I/O block
- io_write  out  1  I/O store
- io_data_out  in  8  I/O read data
- io_data_ready  in  1  I/O completion
- ext_req  out  1  external request; held until ack
- ext_addr  out  8  external address
- ext_wdata  out  8  external store data
- ext_write  out  1  external store
- ext_rdata  in  8  external read data
- ext_ack  in  1  external completion; single cycle

Behaviour:
- All outputs are registered. Reset (rst_n=0 at clk edge) returns the FSM to IDLE and clears all outputs to 0, including any transaction in flight; no ready pulse follows.
- RAM contents are not reset.
- Decode, applied to the address latched in IDLE:
  - 0x00-0x1F: RAM.
  - IO_BASE..IO_TOP: I/O.
  - All other addresses: external.
- FSM states: IDLE, IO_WAIT, EXT_WAIT, RESP.
- IDLE: on mem_req=1, latch addr, wdata and write.
  - RAM target: a store writes the RAM at this edge; a load registers ram[addr[4:0]] into mem_rdata; go to RESP. Latency: req at cycle N, mem_ready at cycle N+1.
  - I/O target: drive io_select=1 with addr, data and write; go to IO_WAIT.
  - External target: drive ext_req=1 with addr, wdata and write; go to EXT_WAIT.
- IO_WAIT: when io_data_ready=1, capture io_data_out into mem_rdata (loads only; stores return 0x00), set io_select=0 and io_write=0, and go to RESP. With the I/O block's one-cycle response, req at N gives mem_ready at N+3.
- EXT_WAIT: when ext_ack=1, capture ext_rdata (loads only), set ext_req=0, and go to RESP. ext_addr, ext_wdata and ext_write stay stable while ext_req=1.
- RESP: mem_ready=1 for exactly one cycle, mem_rdata valid, then return to IDLE.
  - mem_rdata holds its value until the next RESP.
  - mem_ready=0 in every other state.
- mem_req is ignored outside IDLE. If it is still high in the IDLE cycle after RESP, it starts a new transaction. The CPU drops mem_req in the mem_ready cycle to avoid a repeat.
- io_select is low for at least 2 consecutive cycles between I/O transactions (RESP + IDLE). The I/O block sees select held for 2 cycles per access; its write edge guard limits a PINx toggle to once.
- An io_data_ready or ext_ack arriving while the FSM is not in the matching wait state is ignored.
- mem_err=0 without the optional feature.

Optional Feature:
- Macro SPELL_MEM_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to IO_WAIT or EXT_WAIT and increments each wait cycle.
  - When the count reaches TIMEOUT with no ready/ack: drop io_select or ext_req, set mem_rdata=0xFF and mem_err=1 during RESP.
  - If ready/ack and expiry fall in the same cycle, ready/ack wins and mem_err=0.
  - mem_err is cleared at the next request.
- Undefined: waits are unbounded, no counter is built, and mem_err is tied 0.

Test Plan:
- Store 0x5A to 0x07, then load 0x07 -> first mem_ready 1 cycle after req; load returns 0x5A, mem_err=0.
- With the I/O block attached: store 0xF0 to 0x37, then load 0x37 -> mem_rdata=0xF0 at req+3; io_select low ≥2 cycles between the two accesses.
- Store 0x01 to 0x36 twice back-to-back, with mem_req held through ready -> I/O portb_out bit0 goes 0 -> 1 -> 0 (exactly one toggle per store).
- External load from 0x80 with ext_ack after 5 cycles, ext_rdata=0xC3 -> ext_req high 5 cycles, mem_rdata=0xC3 in the RESP cycle.
- rst_n low during EXT_WAIT -> ext_req=0 next cycle, no mem_ready; a following RAM load completes normally.
- With SPELL_MEM_CTRL_TIMEOUT_EN and TIMEOUT=4, external load never acked -> ext_req drops after 4 wait cycles, mem_ready=1, mem_err=1, mem_rdata=0xFF.
